// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, stop_sel encoding, the
// minimum clocks-per-bit clamp and the helpers that interpret them. The
// transmitter and the receiver both use this package so that one
// configuration register drives both directions.
package uart_pkg;

  localparam int unsigned COMP_W   = 16;
  localparam int unsigned COMP_MIN = 4;

  // stop_sel encoding; 2'd3 behaves like STOP_2
  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1_5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // True when the frame carries a second stop bit that must be checked
  function automatic logic two_stop_bits(input logic [1:0] sel);
    case (sel)
      STOP_1, STOP_1_5: two_stop_bits = 1'b0;
      STOP_2:           two_stop_bits = 1'b1;
      default:          two_stop_bits = 1'b1;
    endcase
  endfunction

  // Clocks per bit with the lower clamp applied
  function automatic logic [COMP_W-1:0] comp_clamp(input logic [COMP_W-1:0] c);
    comp_clamp = (c < COMP_W'(COMP_MIN)) ? COMP_W'(COMP_MIN) : c;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for the asynchronous serial input. All stages
// reset to 1 (line idle) so reset release never looks like a start edge.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   din     asynchronous input
//   dout    synchronised output (SYNC_STAGES clocks of latency)
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain; the first stage may go metastable, later stages settle it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver_sv.sv
// UART receiver: samples a synchronised serial line at mid-bit, assembles
// 8 data bits LSB first, checks 1 or 2 stop bits and hands each byte over
// through a valid/ack level handshake.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   comp         clocks per bit (clamped to a minimum of 4)
//   stop_sel     stop bits: 0 = 1, 1 = 1.5, 2/3 = 2
//   rec_en       receiver enable; low aborts a frame and clears overrun
//   uart_rx      asynchronous serial input, idle high
//   rx_data      last received byte
//   rx_valid     rx_data holds an unacknowledged byte
//   rx_ack       consumer acknowledge, honoured only while rx_valid = 1
//   frame_err    stop-bit error for the byte in rx_data
//   overrun      sticky: a byte completed while rx_valid was still set
module uart_receiver_sv
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [COMP_W-1:0] comp,
  input  logic [1:0]        stop_sel,
  input  logic              rec_en,
  input  logic              uart_rx,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              frame_err,
  output logic              overrun
);

  logic rx_s;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .din   (uart_rx),
    .dout  (rx_s)
  );

  rx_state_t         state_q, state_d;
  logic [COMP_W-1:0] cnt_q, cnt_d;
  logic [COMP_W-1:0] comp_q, comp_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_idx_q, stop_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              wait_high_q, wait_high_d;
  logic [7:0]        rx_data_d;
  logic              rx_valid_d;
  logic              frame_err_d;
  logic              overrun_d;

  logic              bit_end;
  logic              half_end;
  logic              stop_err;

  // Counter terminal counts for a full bit and for the half-bit start wait
  assign bit_end  = (cnt_q == comp_q - COMP_W'(1));
  assign half_end = (cnt_q == (comp_q >> 1) - COMP_W'(1));
  // Error accumulated over all stop samples including the current one
  assign stop_err = ferr_q | ~rx_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      comp_q      <= COMP_W'(COMP_MIN);
      two_stop_q  <= 1'b0;
      stop_idx_q  <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      wait_high_q <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      comp_q      <= comp_d;
      two_stop_q  <= two_stop_d;
      stop_idx_q  <= stop_idx_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      wait_high_q <= wait_high_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      frame_err   <= frame_err_d;
      overrun     <= overrun_d;
    end
  end

  // Next-state, sampling and byte delivery
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    comp_d      = comp_q;
    two_stop_d  = two_stop_q;
    stop_idx_d  = stop_idx_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    wait_high_d = wait_high_q;
    rx_data_d   = rx_data;
    rx_valid_d  = rx_valid;
    frame_err_d = frame_err;
    overrun_d   = overrun;

    if (rx_valid && rx_ack) begin
      rx_valid_d = 1'b0;
    end

    // After a frame ending low (break) the line must go idle before re-arming
    if (rx_s) begin
      wait_high_d = 1'b0;
    end

    if (!rec_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_s && !wait_high_q) begin
            state_d    = START;
            comp_d     = comp_clamp(comp);
            two_stop_d = two_stop_bits(stop_sel);
            stop_idx_d = 1'b0;
            bit_idx_d  = '0;
            ferr_d     = 1'b0;
          end
        end

        START: begin
          if (half_end) begin
            cnt_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + COMP_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_d     = '0;
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + COMP_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_d = '0;
            if (two_stop_q && !stop_idx_q) begin
              stop_idx_d = 1'b1;
              ferr_d     = stop_err;
            end else begin
              state_d     = IDLE;
              rx_data_d   = shift_q;
              frame_err_d = stop_err;
              rx_valid_d  = 1'b1;
              wait_high_d = ~rx_s;
              if (rx_valid && !rx_ack) begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + COMP_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver_sv.sv
// Self-checking bench for uart_receiver_sv: a behavioural serial driver
// pushes expected bytes to a scoreboard; a monitor pops and compares on
// each rising edge of rx_valid and optionally acknowledges.
module tb_uart_receiver_sv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] comp = 16'd16;
  logic [1:0]  stop_sel = 2'd0;
  logic        rec_en = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        frame_err;
  logic        overrun;

  uart_receiver_sv #(
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .comp     (comp),
    .stop_sel (stop_sel),
    .rec_en   (rec_en),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  sel;
    logic [15:0] comp;
    logic        stop2;
    logic [7:0]  exp_data;
    logic        exp_ferr;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   deliveries = 0;
  logic auto_ack = 1'b0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic int line_bits(input logic [15:0] c);
    return (c < 16'd4) ? 4 : int'(c);
  endfunction

  // Length of the stop period in half-bit units
  function automatic int stop_halves(input logic [1:0] sel);
    case (sel)
      2'd0:    return 2;
      2'd1:    return 3;
      default: return 4;
    endcase
  endfunction

  task automatic drive_bits(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int c, input int halves, input logic stop2);
    drive_bits(1'b0, c);
    for (int i = 0; i < 8; i++) drive_bits(d[i], c);
    drive_bits(1'b1, c);
    if (halves == 3) drive_bits(1'b1, c / 2);
    else if (halves == 4) drive_bits(stop2, c);
    uart_rx = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic fe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  // Monitor: compare on every new byte, acknowledge when auto_ack is set
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_ack) rx_ack = 1'b0;
      else if (rx_valid && auto_ack) rx_ack = 1'b1;
      if (rx_valid && !valid_prev) begin
        deliveries++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_byte: got 0x%0h with nothing expected", rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("frame_err", 32'(frame_err), 32'(e.ferr));
        end
      end
      valid_prev = rx_valid;
    end
  end

  initial begin
    #(64'd4_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   comps[5];
    int   d0;
    comps = '{64, 32, 16, 9, 2};

    vecs[0] = '{8'h3C, 2'd2, 16'd208, 1'b0, 8'h3C, 1'b1};
    vecs[1] = '{8'h00, 2'd1, 16'd16,  1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 2'd3, 16'd2,   1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h5A, 2'd2, 16'd3,   1'b0, 8'h5A, 1'b1};
    vecs[4] = '{8'h96, 2'd1, 16'd13,  1'b0, 8'h96, 1'b0};
    for (int i = 5; i < 12; i++) begin
      vecs[i].data     = 8'($urandom);
      vecs[i].sel      = 2'($urandom_range(0, 3));
      vecs[i].comp     = 16'(comps[$urandom_range(0, 4)]);
      vecs[i].stop2    = 1'b1;
      vecs[i].exp_data = vecs[i].data;
      vecs[i].exp_ferr = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    resetn = 1'b1;
    rec_en = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 at 434 clocks/bit, held until acknowledged
    comp = 16'd434;
    stop_sel = 2'd0;
    auto_ack = 1'b0;
    @(negedge clk);
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 434, 2, 1'b1);
    repeat (10) @(negedge clk);
    check("a5_valid", 32'(rx_valid), 32'h1);
    repeat (100) @(negedge clk);
    check("a5_valid_held", 32'(rx_valid), 32'h1);
    check("a5_data_held", 32'(rx_data), 32'hA5);
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("a5_valid_after_ack", 32'(rx_valid), 32'h0);
    check("a5_drained", 32'(sb.size()), 32'd0);

    // Table of frames: fixed corner cases plus random loopback traffic
    for (int i = 0; i < 12; i++) begin
      comp = vecs[i].comp;
      stop_sel = vecs[i].sel;
      @(negedge clk);
      expect_byte(vecs[i].exp_data, vecs[i].exp_ferr);
      send_frame(vecs[i].data, line_bits(vecs[i].comp), stop_halves(vecs[i].sel), vecs[i].stop2);
      repeat (3 * line_bits(vecs[i].comp)) @(negedge clk);
      check($sformatf("vec%0d_drained", i), 32'(sb.size()), 32'd0);
    end

    // Glitch shorter than half a bit is a false start
    comp = 16'd64;
    stop_sel = 2'd0;
    d0 = deliveries;
    drive_bits(1'b0, 16);
    drive_bits(1'b1, 3 * 64);
    check("glitch_no_byte", 32'(deliveries), 32'(d0));
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, 64, 2, 1'b1);
    repeat (128) @(negedge clk);
    check("after_glitch_drained", 32'(sb.size()), 32'd0);

    // Two bytes without acknowledge
    auto_ack = 1'b0;
    comp = 16'd32;
    @(negedge clk);
    expect_byte(8'h11, 1'b0);
    send_frame(8'h11, 32, 2, 1'b1);
    send_frame(8'h22, 32, 2, 1'b1);
    repeat (64) @(negedge clk);
    check("ovr_rx_data", 32'(rx_data), 32'h22);
    check("ovr_overrun", 32'(overrun), 32'h1);
    check("ovr_rx_valid", 32'(rx_valid), 32'h1);
    check("ovr_frame_err", 32'(frame_err), 32'h0);

    // rec_en drop mid-frame: abort, clear overrun, hold the byte
    d0 = deliveries;
    drive_bits(1'b0, 5 * 32);
    rec_en = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("dis_overrun_clear", 32'(overrun), 32'h0);
    check("dis_valid_held", 32'(rx_valid), 32'h1);
    check("dis_data_held", 32'(rx_data), 32'h22);
    rec_en = 1'b1;
    drive_bits(1'b1, 12 * 32);
    check("abort_data", 32'(rx_data), 32'h22);
    check("abort_overrun", 32'(overrun), 32'h0);
    check("abort_no_byte", 32'(deliveries), 32'(d0));

    // Reset during data bit 4, then a clean frame
    drive_bits(1'b0, 32);
    for (int i = 0; i < 4; i++) drive_bits(1'(8'hC3 >> i), 32);
    drive_bits(1'b0, 16);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    auto_ack = 1'b1;
    d0 = deliveries;
    drive_bits(1'b1, 64);
    expect_byte(8'h5A, 1'b0);
    send_frame(8'h5A, 32, 2, 1'b1);
    repeat (96) @(negedge clk);
    check("rst_one_byte", 32'(deliveries), 32'(d0 + 1));
    check("rst_drained", 32'(sb.size()), 32'd0);

    // Break: one 0x00 with frame error, no restart while the line stays low
    comp = 16'd16;
    stop_sel = 2'd0;
    @(negedge clk);
    d0 = deliveries;
    expect_byte(8'h00, 1'b1);
    drive_bits(1'b0, 14 * 16);
    check("break_one_byte", 32'(deliveries), 32'(d0 + 1));
    drive_bits(1'b1, 32);
    expect_byte(8'h5B, 1'b0);
    send_frame(8'h5B, 16, 2, 1'b1);
    repeat (48) @(negedge clk);
    check("break_next_byte", 32'(deliveries), 32'(d0 + 2));
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
